// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one registered downstream memory port between the I and D request paths.
// Latency: mem_access rises the cycle after a grant; x_ready returns combinationally with mem_ready.
// Backpressure: requests are held until ready; `ARB_ROUND_ROBIN_EN alternates tie priority (default: D wins).
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [1:0]              i_size,
    output logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [1:0]              d_size,
    input  logic [DATA_WIDTH/8-1:0] d_sel,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_access,
    output logic                    mem_write,
    output logic [1:0]              mem_size,
    output logic [DATA_WIDTH/8-1:0] mem_sel,
    output logic [DATA_WIDTH-1:0]   mem_st_data,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_data
);

    localparam int SEL_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;
    logic                    mem_access_q, mem_access_d;
    logic                    mem_write_q, mem_write_d;
    logic [1:0]              mem_size_q, mem_size_d;
    logic [SEL_W-1:0]        mem_sel_q, mem_sel_d;
    logic [DATA_WIDTH-1:0]   mem_st_data_q, mem_st_data_d;
    logic                    grant_i, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // prefer_i_q=0 means data side wins the next tie.
    logic prefer_i_q, prefer_i_d;

    always_comb begin
        grant_d = d_req & (~i_req | ~prefer_i_q);
        grant_i = i_req & ~grant_d;
    end

    always_comb begin
        prefer_i_d = prefer_i_q;
        if (state_q == IDLE) begin
            if (grant_d) begin
                prefer_i_d = 1'b1;
            end else if (grant_i) begin
                prefer_i_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prefer_i_q <= 1'b0;
        end else begin
            prefer_i_q <= prefer_i_d;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
        grant_i = i_req & ~d_req;
    end
`endif

    always_comb begin
        state_d       = state_q;
        mem_a_d       = mem_a_q;
        mem_access_d  = mem_access_q;
        mem_write_d   = mem_write_q;
        mem_size_d    = mem_size_q;
        mem_sel_d     = mem_sel_q;
        mem_st_data_d = mem_st_data_q;
        i_ready       = 1'b0;
        d_ready       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    mem_a_d       = d_addr;
                    mem_size_d    = d_size;
                    mem_write_d   = d_write;
                    mem_sel_d     = d_sel;
                    mem_st_data_d = d_wdata;
                    mem_access_d  = 1'b1;
                    state_d       = BUSY_D;
                end else if (grant_i) begin
                    mem_a_d       = i_addr;
                    mem_size_d    = i_size;
                    mem_write_d   = 1'b0;
                    mem_sel_d     = '1;
                    mem_st_data_d = '0;
                    mem_access_d  = 1'b1;
                    state_d       = BUSY_I;
                end
            end
            // Downstream fields stay frozen; only completion ends the transfer.
            BUSY_I: begin
                if (mem_ready) begin
                    i_ready      = 1'b1;
                    mem_access_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_ready      = 1'b1;
                    mem_access_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                mem_access_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            mem_a_q       <= '0;
            mem_access_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_size_q    <= '0;
            mem_sel_q     <= '0;
            mem_st_data_q <= '0;
        end else begin
            state_q       <= state_d;
            mem_a_q       <= mem_a_d;
            mem_access_q  <= mem_access_d;
            mem_write_q   <= mem_write_d;
            mem_size_q    <= mem_size_d;
            mem_sel_q     <= mem_sel_d;
            mem_st_data_q <= mem_st_data_d;
        end
    end

    assign mem_a       = mem_a_q;
    assign mem_access  = mem_access_q;
    assign mem_write   = mem_write_q;
    assign mem_size    = mem_size_q;
    assign mem_sel     = mem_sel_q;
    assign mem_st_data = mem_st_data_q;
    assign i_rdata     = mem_data;
    assign d_rdata     = mem_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req;
    logic [31:0] i_addr;
    logic [1:0]  i_size;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_write;
    logic [31:0] d_addr;
    logic [1:0]  d_size;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic [31:0] mem_a;
    logic        mem_access;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic [3:0]  mem_sel;
    logic [31:0] mem_st_data;
    logic        mem_ready;
    logic [31:0] mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_size(d_size), .d_sel(d_sel),
        .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_access(mem_access), .mem_write(mem_write), .mem_size(mem_size),
        .mem_sel(mem_sel), .mem_st_data(mem_st_data), .mem_ready(mem_ready), .mem_data(mem_data)
    );

    typedef struct {
        logic        is_d;
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        glitch;
        logic        exp_write;
        logic [3:0]  exp_sel;
        logic [31:0] exp_st;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        wr;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } req_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        i_req = 1'b0; i_addr = '0; i_size = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_size = '0; d_sel = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_data = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_a"},   64'(mem_a), 64'd0);
        check({tag, "_access"},  64'(mem_access), 64'd0);
        check({tag, "_write"},   64'(mem_write), 64'd0);
        check({tag, "_size"},    64'(mem_size), 64'd0);
        check({tag, "_sel"},     64'(mem_sel), 64'd0);
        check({tag, "_st_data"}, 64'(mem_st_data), 64'd0);
        check({tag, "_readies"}, 64'({i_ready, d_ready}), 64'd0);
    endtask

    // One full transaction from IDLE; starts and ends near a falling edge.
    task automatic run_txn(input vec_t v);
        if (v.is_d) begin
            d_req = 1'b1; d_write = v.write; d_addr = v.addr; d_size = v.size;
            d_sel = v.sel; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr; i_size = v.size;
        end
        @(negedge clk);
        check("txn_access_lat", 64'(mem_access), 64'd1);
        check("txn_mem_a",      64'(mem_a), 64'(v.addr));
        check("txn_mem_size",   64'(mem_size), 64'(v.size));
        check("txn_mem_write",  64'(mem_write), 64'(v.exp_write));
        check("txn_mem_sel",    64'(mem_sel), 64'(v.exp_sel));
        check("txn_mem_st",     64'(mem_st_data), 64'(v.exp_st));
        for (int k = 0; k < v.lat; k++) begin
            if (v.glitch) begin
                d_addr = 32'h0; d_wdata = 32'h0;
            end
            @(negedge clk);
            check("txn_hold_a",   64'(mem_a), 64'(v.addr));
            check("txn_hold_st",  64'(mem_st_data), 64'(v.exp_st));
            check("txn_no_ready", 64'({i_ready, d_ready}), 64'd0);
        end
        mem_ready = 1'b1; mem_data = v.rdata;
        #1;
        check("txn_i_ready", 64'(i_ready), 64'(!v.is_d));
        check("txn_d_ready", 64'(d_ready), 64'(v.is_d));
        if (v.is_d) begin
            if (!v.write) check("txn_d_rdata", 64'(d_rdata), 64'(v.rdata));
        end else begin
            check("txn_i_rdata", 64'(i_rdata), 64'(v.rdata));
        end
        @(negedge clk);
        mem_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;
        #1;
        check("txn_access_drop", 64'(mem_access), 64'd0);
        check("txn_ready_pulse", 64'({i_ready, d_ready}), 64'd0);
        @(negedge clk);
    endtask

    // Waits (bounded) for a grant, checks which side won, completes it, checks the idle gap.
    task automatic serve_expect(input logic exp_d, input logic [31:0] exp_addr, input int lat);
        int n;
        logic [31:0] md;
        n = 0;
        while (!mem_access && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("arb_grant_timeout", 64'(n < 20), 64'd1);
        check("arb_grant_addr",    64'(mem_a), 64'(exp_addr));
        check("arb_grant_write",   64'(mem_write), 64'd0);
        repeat (lat) @(negedge clk);
        md = $urandom;
        mem_ready = 1'b1; mem_data = md;
        #1;
        check("arb_ready_i", 64'(i_ready), 64'(!exp_d));
        check("arb_ready_d", 64'(d_ready), 64'(exp_d));
        check("arb_rdata",   64'(exp_d ? d_rdata : i_rdata), 64'(md));
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("arb_idle_gap", 64'(mem_access), 64'd0);
    endtask

    vec_t vt[5];

    initial begin
        logic [31:0] ia, da;
        req_t pi_f, pd_f, own_f;
        bit   pi, pd, busy, own_d, prefer_i, gd, exp_ir, exp_dr;
        int   lat;
        logic [31:0] md;

        vt[0] = '{is_d:1'b0, write:1'b0, addr:32'h1FC00000, size:2'd2, sel:4'h0, wdata:32'h0,
                  lat:3, rdata:32'h3C1DBFC0, glitch:1'b0, exp_write:1'b0, exp_sel:4'hF, exp_st:32'h0};
        vt[1] = '{is_d:1'b1, write:1'b1, addr:32'h80001000, size:2'd1, sel:4'b0011, wdata:32'hDEADBEEF,
                  lat:2, rdata:32'h0, glitch:1'b0, exp_write:1'b1, exp_sel:4'b0011, exp_st:32'hDEADBEEF};
        vt[2] = '{is_d:1'b1, write:1'b0, addr:32'h00000044, size:2'd2, sel:4'hF, wdata:32'h12345678,
                  lat:0, rdata:32'hA5A55A5A, glitch:1'b0, exp_write:1'b0, exp_sel:4'hF, exp_st:32'h12345678};
        vt[3] = '{is_d:1'b0, write:1'b0, addr:32'hBFC00003, size:2'd0, sel:4'h0, wdata:32'h0,
                  lat:1, rdata:32'h000000FF, glitch:1'b0, exp_write:1'b0, exp_sel:4'hF, exp_st:32'h0};
        vt[4] = '{is_d:1'b1, write:1'b1, addr:32'h80002000, size:2'd2, sel:4'b1100, wdata:32'hCAFEF00D,
                  lat:3, rdata:32'h0, glitch:1'b1, exp_write:1'b1, exp_sel:4'b1100, exp_st:32'hCAFEF00D};

        // Reset state, plus mem_ready in IDLE must be ignored.
        resetn = 1'b0;
        i_req = 1'b0; i_addr = '0; i_size = '0;
        d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_size = '0; d_sel = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_data = '0;
        @(negedge clk);
        check_all_zero("reset");
        resetn = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1; mem_data = 32'h55AA55AA;
        #1;
        check("idle_ready_ignored", 64'({i_ready, d_ready}), 64'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        check("idle_no_access", 64'(mem_access), 64'd0);

        for (int t = 0; t < 5; t++) run_txn(vt[t]);

        // Contention from a fresh reset so the pointer starts data-first.
        reset_dut();
        ia = 32'h00001000; da = 32'h00002000;
`ifdef ARB_ROUND_ROBIN_EN
        i_req = 1'b1; i_addr = ia; i_size = 2'd2;
        d_req = 1'b1; d_write = 1'b0; d_addr = da; d_size = 2'd2; d_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                serve_expect(1'b1, da, 1);
                da = da + 32'd4; d_addr = da;
            end else begin
                serve_expect(1'b0, ia, 1);
                ia = ia + 32'd4; i_addr = ia;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
`else
        for (int r = 0; r < 3; r++) begin
            i_req = 1'b1; i_addr = ia; i_size = 2'd2;
            d_req = 1'b1; d_write = 1'b0; d_addr = da; d_size = 2'd2; d_sel = 4'hF;
            serve_expect(1'b1, da, 1);
            d_req = 1'b0;
            serve_expect(1'b0, ia, 1);
            i_req = 1'b0;
            @(negedge clk);
            ia = ia + 32'h10; da = da + 32'h10;
        end
`endif

        // Reset abort two cycles after a grant with the bridge still pending.
        d_req = 1'b1; d_write = 1'b1; d_addr = 32'h80003000; d_size = 2'd2; d_sel = 4'hF;
        d_wdata = 32'h11223344;
        @(negedge clk);
        check("abort_granted", 64'(mem_access), 64'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_all_zero("abort");
        mem_ready = 1'b1;
        #1;
        check("abort_no_ready", 64'({i_ready, d_ready}), 64'd0);
        @(negedge clk);
        mem_ready = 1'b0; d_req = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        run_txn(vt[0]);

        // Randomized run against a transaction-level model.
        reset_dut();
        pi = 0; pd = 0; busy = 0; own_d = 0; prefer_i = 0; lat = 0;
        pi_f = '0; pd_f = '0; own_f = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!pi && ($urandom % 3 == 0)) begin
                pi = 1;
                pi_f = '{addr:$urandom, size:2'($urandom_range(0, 2)), wr:1'b0, sel:4'h0, wdata:32'h0};
            end
            if (!pd && ($urandom % 3 == 0)) begin
                pd = 1;
                pd_f = '{addr:$urandom, size:2'($urandom_range(0, 2)), wr:1'($urandom),
                         sel:4'($urandom), wdata:$urandom};
            end
            i_req = pi; i_addr = pi_f.addr; i_size = pi_f.size;
            d_req = pd; d_write = pd_f.wr; d_addr = pd_f.addr; d_size = pd_f.size;
            d_sel = pd_f.sel; d_wdata = pd_f.wdata;

            check("rnd_access", 64'(mem_access), 64'(busy));
            if (busy) check("rnd_fields", {mem_a, mem_size, mem_write, mem_sel, mem_st_data}, 64'(own_f));

            md = $urandom;
            mem_data = md;
            mem_ready = (busy && lat == 0) || (!busy && ($urandom % 4 == 0));
            #1;
            exp_ir = busy && lat == 0 && !own_d;
            exp_dr = busy && lat == 0 && own_d;
            check("rnd_i_ready", 64'(i_ready), 64'(exp_ir));
            check("rnd_d_ready", 64'(d_ready), 64'(exp_dr));
            if (exp_ir) check("rnd_i_rdata", 64'(i_rdata), 64'(md));
            if (exp_dr) check("rnd_d_rdata", 64'(d_rdata), 64'(md));

            if (busy) begin
                if (lat == 0) begin
                    busy = 0;
                    if (own_d) pd = 0; else pi = 0;
                end else begin
                    lat--;
                end
            end else if (pi || pd) begin
`ifdef ARB_ROUND_ROBIN_EN
                gd = pd && (!pi || !prefer_i);
`else
                gd = pd;
`endif
                busy = 1;
                own_d = gd;
                lat = $urandom_range(0, 3);
                prefer_i = gd;
                if (gd) own_f = pd_f;
                else own_f = '{addr:pi_f.addr, size:pi_f.size, wr:1'b0, sel:4'hF, wdata:32'h0};
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single simple memory port of the AXI bridge between the instruction-side and data-side cache/fetch paths. It accepts one request at a time, captures its address, size, strobe and store data into registers, and holds them stable on the downstream `mem_*` port until `mem_ready`. It then returns the ready pulse and read data to the granted requester. It sits between the CPU's I/D memory paths and the AXI bridge's cache port.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports.
- `DATA_WIDTH`, 32, data width of all ports; strobe width is `DATA_WIDTH/8`.

- `clk` in 1 — single clock, all logic rising-edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `i_req` in 1 — instruction read request; held with `i_addr`/`i_size` until `i_ready`.
- `i_addr` in 32 — instruction address.
- `i_size` in 2 — transfer size code (0=1B, 1=2B, 2=4B).
- `i_ready` out 1 — one-cycle completion pulse to the instruction side.
- `i_rdata` out 32 — read data, valid only while `i_ready`=1.
- `d_req` in 1 — data request; held with its fields until `d_ready`.
- `d_write` in 1 — 1=store, 0=load.
- `d_addr` in 32 — data address.
- `d_size` in 2 — transfer size code.
- `d_sel` in 4 — byte strobes for stores.
- `d_wdata` in 32 — store data.
- `d_ready` out 1 — one-cycle completion pulse to the data side.
- `d_rdata` out 32 — load data, valid only while `d_ready`=1.
- `mem_a` out 32 — downstream address (registered).
- `mem_access` out 1 — downstream request valid (registered).
- `mem_write` out 1 — downstream write flag (registered).
- `mem_size` out 2 — downstream size (registered).
- `mem_sel` out 4 — downstream strobes (registered).
- `mem_st_data` out 32 — downstream store data (registered).
- `mem_ready` in 1 — downstream completion pulse.
- `mem_data` in 32 — downstream read data, valid with `mem_ready`.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Reset state is IDLE.
- In IDLE, the arbiter grants on the current requests (see Configuration):
  - I granted: load `mem_a`←`i_addr`, `mem_size`←`i_size`, `mem_write`←0, `mem_sel`←4'b1111, `mem_st_data`←0, set `mem_access`=1, go to BUSY_I.
  - D granted: load `mem_a`←`d_addr`, `mem_size`←`d_size`, `mem_write`←`d_write`, `mem_sel`←`d_sel`, `mem_st_data`←`d_wdata`, set `mem_access`=1, go to BUSY_D.
- In BUSY_x, all `mem_*` outputs are frozen. Input changes on either requester are ignored.
- In BUSY_x with `mem_ready`=1:
  - `x_ready`=1 combinationally and `x_rdata`=`mem_data` in the same cycle; the other side's ready stays 0.
  - Next edge: `mem_access`←0, state←IDLE.
- `mem_ready` in IDLE is ignored; no ready pulse is produced.
- `i_rdata`/`d_rdata` are driven from `mem_data` unconditionally and are meaningful only with their ready. `d_rdata` on a store completion is don't-care.
- Reset values: `mem_a`=0, `mem_access`=0, `mem_write`=0, `mem_size`=0, `mem_sel`=0, `mem_st_data`=0, `i_ready`=0, `d_ready`=0, state=IDLE, RR pointer=data-first.
- Reset asserted mid-transaction aborts immediately: all outputs take reset values asynchronously, and no ready pulse is issued. The downstream bridge shares `resetn`.

## Timing
- Request sampled in IDLE at edge N → `mem_access`=1 from cycle N+1.
- Downstream completion at cycle M → requester ready in cycle M, `mem_access`=0 from M+1, state IDLE during M+1.
- Earliest next grant is sampled at the edge ending M+1, so back-to-back downstream accesses have one idle cycle (`mem_access` low) between them. This guarantees the bridge sees a fresh access edge.
- A requester must drop or replace its request in the cycle after its ready. A request still high in IDLE is treated as new.
- Minimum request-to-ready latency is 2 cycles plus the bridge latency.
- Simultaneous `i_req` and `d_req` in IDLE are resolved per Configuration. The loser keeps its request held and is granted on the next IDLE cycle.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - One-bit pointer. After a D grant, I has priority at the next contention; after an I grant, D has priority.
  - Pointer updates only on a grant. It resets to data-first.
- `ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority: D always wins when both request. No pointer register exists.

## Test plan
- Single I read: `i_addr`=0x1FC00000, `i_size`=2, bridge returns `mem_data`=0x3C1DBFC0 after 3 cycles → `mem_access` high 1 cycle after `i_req` with `mem_sel`=4'hF and `mem_write`=0; `i_ready` 1 cycle with `i_rdata`=0x3C1DBFC0; `d_ready` stays 0.
- D store: `d_addr`=0x80001000, `d_sel`=4'b0011, `d_wdata`=0xDEADBEEF, `d_size`=1 → downstream shows exactly these values with `mem_write`=1, held stable until `mem_ready`; `d_ready` pulses once.
- Contention, macro undefined: `i_req` and `d_req` asserted in the same cycle, repeated 3 times → grant order D,I,D,I,…; D always served first on each tie; one idle `mem_access` cycle between grants.
- Contention, `ARB_ROUND_ROBIN_EN` defined: both held high continuously for 4 transactions → grants D,I,D,I.
- Input glitch during BUSY_D: `d_addr` changes to 0x0 mid-transaction → `mem_a` unchanged until completion.
- Reset abort: `resetn` low 2 cycles after grant with `mem_ready` pending → all outputs 0 immediately, no ready pulse, next request after release served normally from IDLE.
